pixel_window_sr: RTL and testbench
==================================

# pixel_window_sr

Parametrised pixel-history shift register for the down-sampling datapath: captures bus samples on a clocked shift strobe, holds the last DEPTH pixels as individually addressable taps, and maintains a running sum of the window for the averaging stage. Its third-order, 8-bit configuration provides the three-deep pixel history. It adds a synchronous clock, clear, rotate mode, fill tracking and a tap mux.

## Interface
- DATA_W, 8, pixel width in bits (1..16)
- DEPTH, 3, number of stages (2..16)
- SEL_W, $clog2(DEPTH), tap-select width (derived, not overridden)
- SUM_W, DATA_W+$clog2(DEPTH), running-sum width (derived)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- clear  in  1  synchronous flush of all stages, sum and fill count
- shift_en  in  1  advance the window this cycle
- rotate  in  1  with shift_en: recirculate the oldest stage into stage 0 instead of din
- din  in  DATA_W  incoming pixel from bus
- tap_sel  in  SEL_W  index of tap to drive on tap_out (0 = newest)
- tap_out  out  DATA_W  selected stage, combinational from registers
- taps_flat  out  DEPTH*DATA_W  all stages, stage k at bits [k*DATA_W +: DATA_W]
- sum_out  out  SUM_W  registered sum of all DEPTH stages
- fill_cnt  out  $clog2(DEPTH+1)  number of valid samples loaded, saturating at DEPTH
- full  out  1  fill_cnt == DEPTH

## Operation
- Stages stg[0..DEPTH-1]. stg[0] is newest, stg[DEPTH-1] is oldest.
- Priority per edge: rst_n low > clear > shift_en > hold.
- Reset and clear have the same effect: all stages, sum_out and fill_cnt go to 0.
- Shift when shift_en=1 and rotate=0:
  - stg[k] <= stg[k-1] for k>=1, and stg[0] <= din.
  - sum_out <= sum_out + din - stg[DEPTH-1], computed in SUM_W bits. The result is exact and never wraps, because sum always equals the stage total.
  - fill_cnt increments, saturating at DEPTH.
- Rotate when shift_en=1 and rotate=1:
  - stg[0] <= stg[DEPTH-1], and the other stages shift as above.
  - sum_out is unchanged.
  - fill_cnt is unchanged.
- Hold when shift_en=0: all state holds, and rotate and din are ignored.
- tap_out = stg[tap_sel] when tap_sel < DEPTH, and 0 otherwise (reachable when DEPTH is not a power of two).
- Invariant: sum_out equals the arithmetic sum of taps_flat stages at every cycle. Verification asserts this continuously.
- Stages that have not been loaded hold 0, so the partial sum during fill is valid. The downstream divider uses fill_cnt as the divisor until full.

## Timing
- All state is updated on the rising edge of clk. No logic is level-sensitive to din.
- Shift latency is 1 cycle. din sampled at edge N appears on stg[0], taps_flat and sum_out after edge N, and at stg[k] after k+1 shift edges.
- shift_en may be held high for back-to-back shifts, one sample per cycle, with no bubbles.
- tap_out follows tap_sel combinationally in the same cycle, and follows stage data after the register edge.
- clear asserted together with shift_en: clear wins and din is discarded. The first post-clear sample needs a new shift_en.
- Reset mid-stream: outputs read 0 after the first clocked edge with rst_n low. Reset is not effective without a clock edge.
- Saturation: when full=1, further shifts keep fill_cnt=DEPTH and full=1, and the oldest sample is discarded.
- Rotate before full: unloaded zero stages recirculate. This is legal and fill_cnt stays unchanged.

## Test plan
- Reset and fill (DEPTH=3, DATA_W=8):
  - Stimulus: rst_n low for 2 cycles, then shift din=10, 20, 30 on consecutive cycles.
  - Response: after each edge, stg = {10,0,0} → {20,10,0} → {30,20,10}.
  - sum_out = 10 → 30 → 60, and fill_cnt = 1 → 2 → 3, with full=1 after the third edge.
- Overflow eviction:
  - Stimulus: from {30,20,10}, shift din=255 twice.
  - Response: stg = {255,30,20} with sum 305, then {255,255,30} with sum 540. fill_cnt stays at 3.
- Maximum sum:
  - Stimulus: shift 255 three times.
  - Response: sum_out = 765 (10 bits, no wrap).
  - Then shift 0 three times: sum_out = 510 → 255 → 0.
- Rotate:
  - Stimulus: from {30,20,10}, assert rotate+shift_en for 1 cycle, then for 3 cycles.
  - Response: {10,30,20} with sum 60. After the three further rotates the window is back to {10,30,20}, and fill_cnt stays at 3.
- Clear priority and hold:
  - Stimulus: clear=1 with shift_en=1 and din=99.
  - Response: all stages 0, sum 0, fill_cnt 0.
  - Then shift_en=0 with din toggling for 5 cycles: state stays unchanged.
- Tap mux:
  - Stimulus: with {30,20,10}, tap_sel = 0, 1, 2, 3 in one cycle each, no clock edge required.
  - Response: tap_out = 30, 20, 10, 0.
  - Repeat the fill test with DEPTH=5 and DATA_W=12, and check that sum_out tracks the window with SUM_W=15.

Source files
------------

// File: rtl/pixel_window_sr_if.sv
// Bus bundle for pixel_window_sr: window controls and pixel in (master),
// taps, running sum and fill status out (slave = the shift register).
interface pixel_window_sr_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3
);
  localparam int SEL_W = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    clear;
  logic                    shift_en;
  logic                    rotate;
  logic [DATA_W-1:0]       din;
  logic [SEL_W-1:0]        tap_sel;
  logic [DATA_W-1:0]       tap_out;
  logic [DEPTH*DATA_W-1:0] taps_flat;
  logic [SUM_W-1:0]        sum_out;
  logic [CNT_W-1:0]        fill_cnt;
  logic                    full;

  modport master (
    output clear, shift_en, rotate, din, tap_sel,
    input  tap_out, taps_flat, sum_out, fill_cnt, full
  );

  modport slave (
    input  clear, shift_en, rotate, din, tap_sel,
    output tap_out, taps_flat, sum_out, fill_cnt, full
  );
endinterface

// File: rtl/pixel_window_sr.sv
// Pixel-history shift register: DEPTH taps, running window sum, fill count.
// Ports: clk, rst_n (sync, active-low), bus (slave: controls in, taps/sum out).
module pixel_window_sr #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  pixel_window_sr_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] stg_q [DEPTH];
  logic [DATA_W-1:0] stg_d [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  fill_q, fill_d;

  always_comb begin
    stg_d  = stg_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (bus.clear) begin
      for (int k = 0; k < DEPTH; k++) stg_d[k] = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (bus.shift_en) begin
      for (int k = 1; k < DEPTH; k++) stg_d[k] = stg_q[k-1];
      if (bus.rotate) begin
        // recirculation keeps the same multiset, so sum is unchanged
        stg_d[0] = stg_q[DEPTH-1];
      end else begin
        stg_d[0] = bus.din;
        // intermediate may wrap; final value equals the exact stage total
        sum_d = sum_q + SUM_W'(bus.din)
              - SUM_W'(stg_q[DEPTH-1]);
        if (fill_q != CNT_W'(DEPTH)) fill_d = fill_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stg_q[k] <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      stg_q  <= stg_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end

  always_comb begin
    bus.tap_out   = '0;
    bus.taps_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.taps_flat[k*DATA_W +: DATA_W] = stg_q[k];
      // out-of-range selects fall through to zero
      if (bus.tap_sel == SEL_W'(k)) bus.tap_out = stg_q[k];
    end
  end

  assign bus.sum_out  = sum_q;
  assign bus.fill_cnt = fill_q;
  assign bus.full     = (fill_q == CNT_W'(DEPTH));
endmodule

// File: tb/tb_pixel_window_sr.sv
// Scoreboard bench for pixel_window_sr in two configurations (8b x3, 12b x5).
// Both instances see the same controls; a window model predicts each edge.
module tb_pixel_window_sr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  pixel_window_sr_if #(.DATA_W(8),  .DEPTH(3)) bus0 ();
  pixel_window_sr_if #(.DATA_W(12), .DEPTH(5)) bus1 ();

  pixel_window_sr #(.DATA_W(8), .DEPTH(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );
  pixel_window_sr #(.DATA_W(12), .DEPTH(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  typedef struct packed {
    int              due;
    int              sum;
    int              fill;
    logic [15:0][15:0] taps;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int w [2][16];
  int mfill [2];
  int dep [2] = '{3, 5};
  int dmask [2] = '{255, 4095};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, integer act, integer exp_v);
    nchk++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic exp_t snap(int i);
    exp_t e;
    e.due  = cyc + 1;
    e.fill = mfill[i];
    e.sum  = 0;
    e.taps = '0;
    for (int k = 0; k < dep[i]; k++) begin
      e.taps[k] = 16'(w[i][k]);
      e.sum += w[i][k];
    end
    return e;
  endfunction

  // window model: newest at w[i][0]; sum is recomputed from the window
  task automatic model(int i, bit rn, bit clr, bit sh, bit rot, int d);
    int nw;
    if (!rn || clr) begin
      for (int k = 0; k < 16; k++) w[i][k] = 0;
      mfill[i] = 0;
    end else if (sh) begin
      nw = rot ? w[i][dep[i]-1] : (d & dmask[i]);
      for (int k = dep[i] - 1; k > 0; k--) w[i][k] = w[i][k-1];
      w[i][0] = nw;
      if (!rot && mfill[i] < dep[i]) mfill[i]++;
    end
  endtask

  task automatic drive(bit rn, bit clr, bit sh, bit rot, int d, int sel);
    @(posedge clk);
    #1;
    rst_n         = rn;
    bus0.clear    = clr;
    bus1.clear    = clr;
    bus0.shift_en = sh;
    bus1.shift_en = sh;
    bus0.rotate   = rot;
    bus1.rotate   = rot;
    bus0.din      = 8'(d);
    bus1.din      = 12'(d);
    bus0.tap_sel  = 2'(sel);
    bus1.tap_sel  = 3'(sel);
    model(0, rn, clr, sh, rot, d);
    model(1, rn, clr, sh, rot, d);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t   e;
      bit     have;
      integer tp [16];
      integer s, f, fl, to, tsum;
      int     sel;
      have = 1'b0;
      e = '0;
      s = 0; f = 0; fl = 0; to = 0; sel = 0;
      for (int k = 0; k < 16; k++) tp[k] = 0;
      if (i == 0) begin
        if (q0.size() > 0 && q0[0].due <= cyc) begin
          e = q0.pop_front();
          have = 1'b1;
        end
      end else begin
        if (q1.size() > 0 && q1[0].due <= cyc) begin
          e = q1.pop_front();
          have = 1'b1;
        end
      end
      if (have) begin
        if (i == 0) begin
          for (int k = 0; k < 3; k++) tp[k] = bus0.taps_flat[k*8 +: 8];
          s = bus0.sum_out; f = bus0.fill_cnt; fl = bus0.full;
          to = bus0.tap_out; sel = int'(bus0.tap_sel);
        end else begin
          for (int k = 0; k < 5; k++) tp[k] = bus1.taps_flat[k*12 +: 12];
          s = bus1.sum_out; f = bus1.fill_cnt; fl = bus1.full;
          to = bus1.tap_out; sel = int'(bus1.tap_sel);
        end
        chk($sformatf("d%0d due", i), cyc, e.due);
        tsum = 0;
        for (int k = 0; k < dep[i]; k++) begin
          chk($sformatf("d%0d tap%0d", i, k), tp[k], e.taps[k]);
          tsum += tp[k];
        end
        chk($sformatf("d%0d sum", i), s, e.sum);
        chk($sformatf("d%0d sum_invariant", i), s, tsum);
        chk($sformatf("d%0d fill", i), f, e.fill);
        chk($sformatf("d%0d full", i), fl, (e.fill == dep[i]) ? 1 : 0);
        chk($sformatf("d%0d tap_out sel%0d", i, sel), to,
            (sel < dep[i]) ? int'(e.taps[sel]) : 0);
      end
    end
  end

  initial begin
    int tv [4];
    int r;
    tv = '{30, 20, 10, 0};
    bus0.clear = 0; bus0.shift_en = 0; bus0.rotate = 0;
    bus0.din = '0;  bus0.tap_sel = '0;
    bus1.clear = 0; bus1.shift_en = 0; bus1.rotate = 0;
    bus1.din = '0;  bus1.tap_sel = '0;

    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 10, 0);
    drive(1, 0, 1, 0, 20, 1);
    drive(1, 0, 1, 0, 30, 2);
    drive(1, 0, 0, 0, 77, 0);
    chk("fill sum60", bus0.sum_out, 60);
    chk("fill full", bus0.full, 1);
    for (int s = 0; s < 4; s++) begin
      bus0.tap_sel = 2'(s);
      #1;
      chk($sformatf("mux sel%0d", s), bus0.tap_out, tv[s]);
    end

    drive(1, 0, 1, 0, 255, 0);
    drive(1, 0, 1, 0, 255, 1);
    drive(1, 0, 1, 0, 255, 2);
    drive(1, 0, 0, 0, 5, 0);
    chk("max sum765", bus0.sum_out, 765);
    for (int n = 0; n < 3; n++) drive(1, 0, 1, 0, 0, n);

    for (int n = 1; n <= 3; n++) drive(1, 0, 1, 0, n * 10, 0);
    drive(1, 0, 1, 1, 99, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rot tap0", bus0.taps_flat[7:0], 10);
    chk("rot tap1", bus0.taps_flat[15:8], 30);
    chk("rot tap2", bus0.taps_flat[23:16], 20);
    for (int n = 0; n < 3; n++) drive(1, 0, 1, 1, 44, n);

    drive(1, 1, 1, 0, 99, 0);
    for (int n = 0; n < 5; n++)
      drive(1, 0, 0, n[0], (n[0] ? 255 : 0), n);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      drive(r != 0, r inside {[1:2]}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, int'($urandom),
            $urandom_range(0, 7));
    end
    drive(1, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("drain q0", q0.size(), 0);
    chk("drain q1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
